// File: rtl/sprite_pixel_packer_pkg.sv
// ============================================================================
// Module  : sprite_pixel_packer_pkg
// Brief   : Shared palette, packing constants and FSM state type for the
//           sprite pixel packer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_pixel_packer_pkg;

  localparam int c_PIX_PER_WORD = 8;
  localparam int c_NIB_W        = 4;

  // 16-entry RGB444 palette, identical to the table used by the readers.
  // Entry 12 repeats black on purpose: the lowest index must win.
  localparam logic [11:0] c_PALETTE [16] = '{
    12'hFFF, 12'h653, 12'hE12, 12'hEB6,
    12'h000, 12'h521, 12'hA86, 12'h211,
    12'h3A5, 12'h58C, 12'h8CF, 12'hF80,
    12'h000, 12'h7F7, 12'hC4E, 12'h444
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } pack_state_t;

endpackage

`default_nettype wire

// File: rtl/sprite_pixel_packer_if.sv
// ============================================================================
// Module  : sprite_pixel_packer_if
// Brief   : Pixel stream (valid/ready) and BRAM write port bundle.
//           master = loader / BRAM side, slave = packer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface sprite_pixel_packer_if #(
  parameter int ADDR_W = 12
);

  logic              pix_valid;
  logic              pix_ready;
  logic [11:0]       pix_rgb;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output pix_valid,
    output pix_rgb,
    input  pix_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  pix_valid,
    input  pix_rgb,
    output pix_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/sprite_pixel_packer_palette_encoder.sv
// ============================================================================
// Module  : palette_encoder
// Brief   : Combinational RGB444 -> 4-bit palette index, exact match,
//           lowest matching index wins.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module palette_encoder
  import sprite_pixel_packer_pkg::*;
(
  input  logic [11:0] i_rgb,
  output logic        o_hit,
  output logic [3:0]  o_idx
);

  // Scan from the top down so the lowest matching entry is the last writer.
  always_comb begin
    o_hit = 1'b0;
    o_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (i_rgb == c_PALETTE[i]) begin
        o_hit = 1'b1;
        o_idx = 4'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sprite_pixel_packer.sv
// ============================================================================
// Module  : sprite_pixel_packer
// Brief   : Encodes a raster of RGB444 pixels to palette indices, packs eight
//           nibbles per 32-bit word and writes them to sprite BRAM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_pixel_packer
  import sprite_pixel_packer_pkg::*;
#(
  parameter int          SPRITE_W = 20,
  parameter int          SPRITE_H = 20,
  parameter int          ADDR_W   = 12,
  parameter logic [3:0]  MISS_IDX = 4'd0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  sprite_pixel_packer_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic [15:0]       miss_count
);

  localparam int c_TOTAL      = SPRITE_W * SPRITE_H;
  localparam int c_CNT_RAW    = $clog2(c_TOTAL + 1);
  // At least 3 bits so the nibble position can always be sliced out.
  localparam int c_CNT_W      = (c_CNT_RAW < 3) ? 3 : c_CNT_RAW;
  localparam bit c_NEED_FLUSH = (c_TOTAL % c_PIX_PER_WORD) != 0;

  pack_state_t       r_state;
  pack_state_t       w_state_next;
  logic              w_ready;
  logic              w_xfer;
  logic              w_last;
  logic              w_hit;
  logic [3:0]        w_enc_idx;
  logic [3:0]        w_idx;
  logic [2:0]        w_nib_pos;
  logic [31:0]       w_acc_next;

  logic [c_CNT_W-1:0] r_pix_cnt;
  logic [31:0]        r_acc;
  logic [ADDR_W-1:0]  r_word_addr;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic [15:0]        r_miss_count;

  palette_encoder u_enc (
    .i_rgb (bus.pix_rgb),
    .o_hit (w_hit),
    .o_idx (w_enc_idx)
  );

  assign w_idx      = w_hit ? w_enc_idx : MISS_IDX;
  assign w_xfer     = bus.pix_valid & w_ready;
  assign w_last     = (r_pix_cnt == c_CNT_W'(c_TOTAL - 1));
  assign w_nib_pos  = r_pix_cnt[2:0];
  // Nibbles not yet filled stay zero, so OR-ing in the new index is enough.
  assign w_acc_next = r_acc | ({28'd0, w_idx} << {w_nib_pos, 2'b00});

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = FILL;
        end
      end
      FILL: begin
        w_ready = 1'b1;
        busy    = 1'b1;
        if (w_xfer && w_last) begin
          w_state_next = c_NEED_FLUSH ? FLUSH : DONE;
        end
      end
      FLUSH: begin
        busy         = 1'b1;
        w_state_next = DONE;
      end
      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Pixel counter, nibble accumulator, miss counter and BRAM write port.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pix_cnt    <= '0;
      r_acc        <= 32'd0;
      r_word_addr  <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'd0;
      r_miss_count <= 16'd0;
    end else begin
      r_mem_we <= 1'b0;

      if (r_state == IDLE && start) begin
        r_word_addr  <= base_addr;
        r_pix_cnt    <= '0;
        r_acc        <= 32'd0;
        r_miss_count <= 16'd0;
      end

      if (w_xfer) begin
        r_pix_cnt <= r_pix_cnt + c_CNT_W'(1);
        if (!w_hit && r_miss_count != 16'hFFFF) begin
          r_miss_count <= r_miss_count + 16'd1;
        end
        // Eighth nibble: emit the word and clear the accumulator on the same
        // edge so the next pixel can be taken without a bubble.
        if (w_nib_pos == 3'd7) begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_word_addr;
          r_mem_wdata <= w_acc_next;
          r_word_addr <= r_word_addr + ADDR_W'(1);
          r_acc       <= 32'd0;
        end else begin
          r_acc <= w_acc_next;
        end
      end

      if (r_state == FLUSH) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_word_addr;
        r_mem_wdata <= r_acc;
        r_word_addr <= r_word_addr + ADDR_W'(1);
        r_acc       <= 32'd0;
      end
    end
  end

  assign bus.pix_ready = w_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign miss_count    = r_miss_count;

endmodule

`default_nettype wire

// File: tb/tb_sprite_pixel_packer.sv
// ============================================================================
// Module  : tb_sprite_pixel_packer
// Brief   : Self-checking bench: a 20x20 and a 3x3 packer driven with
//           random and directed pixel streams against a word-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sprite_pixel_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [11:0] base_a = 12'd0, base_b = 12'd0;
  logic        busy_a, done_a, busy_b, done_b;
  logic [15:0] miss_a, miss_b;

  always #5 clk = ~clk;

  sprite_pixel_packer_if #(.ADDR_W(12)) ifa ();
  sprite_pixel_packer_if #(.ADDR_W(12)) ifb ();

  sprite_pixel_packer #(.SPRITE_W(20), .SPRITE_H(20), .ADDR_W(12), .MISS_IDX(4'd0)) dut_a (
    .Clk(clk), .Reset(rst), .start(start_a), .base_addr(base_a), .bus(ifa),
    .busy(busy_a), .done(done_a), .miss_count(miss_a)
  );

  sprite_pixel_packer #(.SPRITE_W(3), .SPRITE_H(3), .ADDR_W(12), .MISS_IDX(4'd0)) dut_b (
    .Clk(clk), .Reset(rst), .start(start_b), .base_addr(base_b), .bus(ifb),
    .busy(busy_b), .done(done_b), .miss_count(miss_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] pal [16] = '{
    12'hFFF, 12'h653, 12'hE12, 12'hEB6, 12'h000, 12'h521, 12'hA86, 12'h211,
    12'h3A5, 12'h58C, 12'h8CF, 12'hF80, 12'h000, 12'h7F7, 12'hC4E, 12'h444
  };

  logic [11:0] pix [$];
  int          exp_addr_a [$], exp_addr_b [$];
  logic [31:0] exp_data_a [$], exp_data_b [$];
  int          log_addr_a [$], log_addr_b [$];
  logic [31:0] log_data_a [$], log_data_b [$];
  int          done_cnt [2];
  int          left_at_done [2];
  int          exp_miss;
  int          last_addr;
  logic [31:0] last_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // {hit, idx}: first palette entry equal to the colour.
  function automatic logic [4:0] enc(input logic [11:0] c);
    for (int i = 0; i < 16; i++) begin
      if (pal[i] == c) return {1'b1, 4'(i)};
    end
    return 5'd0;
  endfunction

  // Expected words for the current pixel list: word w holds pixels 8w..8w+7.
  task automatic model(input bit sel, input int base, input int total, input int nwords);
    logic [4:0]  e;
    logic [31:0] word;
    int          a;
    exp_miss = 0;
    for (int p = 0; p < total; p++) begin
      e = enc(pix[p]);
      if (!e[4] && exp_miss < 65535) exp_miss++;
    end
    for (int w = 0; w < nwords; w++) begin
      word = 32'd0;
      for (int k = 0; k < 8; k++) begin
        if (8 * w + k < total) begin
          e = enc(pix[8 * w + k]);
          word = word | (32'(e[3:0]) << (4 * k));
        end
      end
      a = (base + w) % 4096;
      if (sel) begin exp_addr_b.push_back(a); exp_data_b.push_back(word); end
      else     begin exp_addr_a.push_back(a); exp_data_a.push_back(word); end
      last_addr = a;
      last_data = word;
    end
  endtask

  task automatic mon_write(input bit sel, input int addr, input logic [31:0] data);
    int          ea;
    logic [31:0] ed;
    if (sel) begin
      log_addr_b.push_back(addr); log_data_b.push_back(data);
      if (exp_addr_b.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_write_b: got addr %0h data %08h expected no write", addr, data);
        return;
      end
      ea = exp_addr_b.pop_front(); ed = exp_data_b.pop_front();
    end else begin
      log_addr_a.push_back(addr); log_data_a.push_back(data);
      if (exp_addr_a.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_write_a: got addr %0h data %08h expected no write", addr, data);
        return;
      end
      ea = exp_addr_a.pop_front(); ed = exp_data_a.pop_front();
    end
    check(sel ? "wr_addr_b" : "wr_addr_a", 64'(addr), 64'(ea));
    check(sel ? "wr_data_b" : "wr_data_a", 64'(data), 64'(ed));
  endtask

  // Compare process: every write and every done pulse, both DUTs.
  always @(negedge clk) begin
    if (ifa.mem_we) mon_write(1'b0, int'(ifa.mem_addr), ifa.mem_wdata);
    if (ifb.mem_we) mon_write(1'b1, int'(ifb.mem_addr), ifb.mem_wdata);
    if (done_a) begin done_cnt[0]++; left_at_done[0] = exp_addr_a.size(); end
    if (done_b) begin done_cnt[1]++; left_at_done[1] = exp_addr_b.size(); end
  end

  task automatic drive(input bit sel, input logic v, input logic [11:0] rgb,
                       input logic st, input logic [11:0] base);
    if (sel) begin ifb.pix_valid = v; ifb.pix_rgb = rgb; start_b = st; base_b = base; end
    else     begin ifa.pix_valid = v; ifa.pix_rgb = rgb; start_a = st; base_a = base; end
  endtask

  function automatic logic get_ready(input bit sel);
    return sel ? ifb.pix_ready : ifa.pix_ready;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  // Starts a sprite, streams pix[0..stop_after-1] with random valid gaps,
  // optionally pulses a stray start, then waits for and checks completion.
  task automatic run_sprite(input bit sel, input int base, input int gap_pct,
                            input int stop_after, input int bogus_at);
    int          total, lim, i, cyc, d0;
    logic        v, acc;
    logic [11:0] cur_base;
    total    = sel ? 9 : 400;
    lim      = (stop_after < total) ? stop_after : total;
    d0       = done_cnt[sel];
    cur_base = 12'(base);
    @(posedge clk); #1; drive(sel, 1'b0, 12'd0, 1'b1, cur_base);
    @(posedge clk); #1; drive(sel, 1'b0, 12'd0, 1'b0, cur_base);
    @(negedge clk);
    check("busy_after_start", 64'(get_busy(sel)), 64'd1);
    @(posedge clk); #1;
    i = 0; cyc = 0;
    while (i < lim && cyc < 5000) begin
      v = ($urandom_range(0, 99) >= gap_pct);
      if (i == bogus_at) cur_base = 12'd777;
      drive(sel, v, v ? pix[i] : 12'($urandom), (i == bogus_at), cur_base);
      @(negedge clk); acc = v && get_ready(sel);
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    drive(sel, 1'b0, 12'd0, 1'b0, cur_base);
    if (i < lim) begin
      n_cmp++; n_err++;
      $display("FAIL pixel_feed_timeout: got %0d pixels accepted expected %0d", i, lim);
    end
    if (lim < total) return;
    cyc = 0;
    while (done_cnt[sel] == d0 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("done_pulses", 64'(done_cnt[sel] - d0), 64'd1);
    check("writes_before_done", 64'(left_at_done[sel]), 64'd0);
    check("pending_writes", 64'(sel ? exp_addr_b.size() : exp_addr_a.size()), 64'd0);
    check("miss_count", 64'(sel ? miss_b : miss_a), 64'(exp_miss));
    check("busy_after_done", 64'(get_busy(sel)), 64'd0);
    check("addr_hold", 64'(sel ? ifb.mem_addr : ifa.mem_addr), 64'(last_addr));
    check("data_hold", 64'(sel ? ifb.mem_wdata : ifa.mem_wdata), 64'(last_data));
  endtask

  task automatic gen_random(input int n, input bit hits_only);
    pix.delete();
    for (int k = 0; k < n; k++) begin
      if (hits_only || $urandom_range(0, 3) != 0) pix.push_back(pal[$urandom_range(0, 15)]);
      else                                        pix.push_back(12'($urandom));
    end
  endtask

  task automatic clear_logs();
    log_addr_a.delete(); log_data_a.delete();
    log_addr_b.delete(); log_data_b.delete();
  endtask

  initial begin
    logic [31:0] saved [$];
    int          diffs;
    logic [11:0] first8 [8];
    first8 = '{12'hFFF, 12'h653, 12'hE12, 12'hEB6, 12'h000, 12'h521, 12'hA86, 12'h211};
    drive(1'b0, 1'b0, 12'd0, 1'b0, 12'd0);
    drive(1'b1, 1'b0, 12'd0, 1'b0, 12'd0);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pix_ready", 64'(ifa.pix_ready), 64'd0);
    check("rst_mem_we", 64'(ifa.mem_we), 64'd0);
    check("rst_mem_addr", 64'(ifa.mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(ifa.mem_wdata), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_miss", 64'(miss_a), 64'd0);
    check("rst_busy_b", 64'(busy_b), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed first word at base 100
    gen_random(400, 1'b0);
    for (int k = 0; k < 8; k++) pix[k] = first8[k];
    clear_logs(); model(1'b0, 100, 400, 50);
    run_sprite(1'b0, 100, 0, 400, -1);
    check("first_word_addr", 64'(log_addr_a[0]), 64'd100);
    check("first_word_data", 64'(log_data_a[0]), 64'h76543210);

    // E12 / 000 alternating, 50 identical words
    pix.delete();
    for (int k = 0; k < 400; k++) pix.push_back((k % 2 == 0) ? 12'hE12 : 12'h000);
    clear_logs(); model(1'b0, 0, 400, 50);
    run_sprite(1'b0, 0, 0, 400, -1);
    check("alt_write_count", 64'(log_addr_a.size()), 64'd50);
    check("alt_last_addr", 64'(log_addr_a[49]), 64'd49);
    check("alt_last_data", 64'(log_data_a[49]), 64'h42424242);

    // 3x3 sprite of black, partial flush word
    pix.delete();
    for (int k = 0; k < 9; k++) pix.push_back(12'h000);
    clear_logs(); model(1'b1, 5, 9, 2);
    run_sprite(1'b1, 5, 0, 9, -1);
    check("small_w0", 64'(log_data_b[0]), 64'h44444444);
    check("small_a1", 64'(log_addr_b[1]), 64'd6);
    check("small_w1", 64'(log_data_b[1]), 64'h00000004);

    // One miss, gap-free then with random gaps: identical words
    gen_random(400, 1'b1);
    pix[37] = 12'h123;
    clear_logs(); model(1'b0, 200, 400, 50);
    run_sprite(1'b0, 200, 0, 400, -1);
    check("miss_one", 64'(miss_a), 64'd1);
    check("miss_nibble", 64'((log_data_a[4] >> 20) & 32'hF), 64'd0);
    saved = log_data_a;
    clear_logs(); model(1'b0, 200, 400, 50);
    run_sprite(1'b0, 200, 50, 400, -1);
    diffs = 0;
    for (int k = 0; k < 50; k++) if (log_data_a[k] !== saved[k]) diffs++;
    check("gapped_vs_gapfree", 64'(diffs), 64'd0);

    // Reset after 13 pixels, then a clean restart
    gen_random(400, 1'b0);
    clear_logs(); model(1'b0, 300, 400, 1);
    run_sprite(1'b0, 300, 0, 13, -1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 64'(busy_a), 64'd0);
    check("rst_mid_ready", 64'(ifa.pix_ready), 64'd0);
    repeat (20) @(posedge clk);
    check("rst_mid_writes", 64'(log_addr_a.size()), 64'd1);
    clear_logs(); model(1'b0, 300, 400, 50);
    run_sprite(1'b0, 300, 10, 400, -1);
    check("restart_first_addr", 64'(log_addr_a[0]), 64'd300);

    // Stray start while busy
    gen_random(400, 1'b0);
    clear_logs(); model(1'b0, 400, 400, 50);
    run_sprite(1'b0, 400, 20, 400, 50);
    check("stray_start_count", 64'(log_addr_a.size()), 64'd50);

    // Address wrap
    gen_random(400, 1'b0);
    clear_logs(); model(1'b0, 4090, 400, 50);
    run_sprite(1'b0, 4090, 30, 400, -1);
    check("wrap_addr", 64'(log_addr_a[6]), 64'd0);

    // Random small sprites with gaps, wrapping base
    for (int r = 0; r < 4; r++) begin
      gen_random(9, 1'b0);
      clear_logs(); model(1'b1, 4095 - r, 9, 2);
      run_sprite(1'b1, 4095 - r, 40, 9, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
